// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW/load-use stall, branch flush, memory freeze with timeout.
// Define PIPE_HAZARD_FORWARDING_EN to restrict hazard detection to load-use only.
module pipe_hazard_ctrl #(
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_src1,
  input  logic [4:0]             id_src2,
  input  logic                   id_two_src,
  input  logic [4:0]             exe_dest,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [4:0]             mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   br_taken,
  input  logic                   mem_access,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_exe_en,
  output logic                   exe_mem_en,
  output logic                   mem_wb_reg_en,
  output logic                   if_id_flush,
  output logic                   id_exe_bubble,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   br_pend_q, br_pend_d;
  logic                   mem_err_q, mem_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic s1_exe, s2_exe, s1_mem, s2_mem;
  logic hazard, freeze, branch;
  logic unused_inputs;

  function automatic logic src_match(input logic [4:0] src, input logic [4:0] dest);
    return (src == dest) && (src != 5'd0);
  endfunction

  assign s1_exe = src_match(id_src1, exe_dest);
  assign s2_exe = id_two_src && src_match(id_src2, exe_dest);
  assign s1_mem = src_match(id_src1, mem_dest);
  assign s2_mem = id_two_src && src_match(id_src2, mem_dest);

`ifdef PIPE_HAZARD_FORWARDING_EN
  assign hazard        = exe_mem_r_en && (s1_exe || s2_exe);
  assign unused_inputs = ^{exe_wb_en, mem_wb_en, s1_mem, s2_mem};
`else
  assign hazard        = (exe_wb_en && (s1_exe || s2_exe)) ||
                         (mem_wb_en && (s1_mem || s2_mem));
  assign unused_inputs = exe_mem_r_en;
`endif

  // A branch seen while EXE is frozen is remembered until the freeze lifts.
  assign freeze = mem_access && !mem_ready && (wait_cnt_q != MEM_TIMEOUT);
  assign branch = br_taken || br_pend_q;

  // Pipeline enables; reset forces pass-through so registers clear themselves.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    mem_wb_reg_en = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    if (rst) begin
      if (freeze) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        mem_wb_reg_en = 1'b0;
      end else if (branch) begin
        if_id_flush   = 1'b1;
        id_exe_bubble = 1'b1;
      end else if (hazard) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = freeze ? WAIT : IDLE;
    wait_cnt_d  = freeze ? wait_cnt_q + 8'd1 : 8'd0;
    br_pend_d   = freeze && (br_pend_q || br_taken);
    mem_err_d   = mem_err_q ||
                  ((state_q == WAIT) && (wait_cnt_q == MEM_TIMEOUT) && !mem_ready);
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      br_pend_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      br_pend_q   <= br_pend_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner sequences and random run against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;
`ifdef PIPE_HAZARD_FORWARDING_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    id_src1, id_src2, exe_dest, mem_dest;
  logic          id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, br_taken;
  logic          mem_access, mem_ready;
  logic          pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en;
  logic          if_id_flush, id_exe_bubble, mem_err;
  logic [SW-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8'(TO)), .STALL_CNT_W(SW)) u_dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .exe_mem_en(exe_mem_en), .mem_wb_reg_en(mem_wb_reg_en),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: consecutive frozen cycles, held branch, sticky error, stall count.
  int m_run;
  bit m_pend, m_err;
  int m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    logic [4:0] srcs[$];
    logic [4:0] prods[$];
    srcs.push_back(id_src1);
    if (id_two_src) srcs.push_back(id_src2);
`ifdef PIPE_HAZARD_FORWARDING_EN
    if (exe_mem_r_en) prods.push_back(exe_dest);
`else
    if (exe_wb_en) prods.push_back(exe_dest);
    if (mem_wb_en) prods.push_back(mem_dest);
`endif
    for (int i = 0; i < srcs.size(); i++)
      for (int j = 0; j < prods.size(); j++)
        if (srcs[i] != 5'd0 && srcs[i] == prods[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_freeze();
    return mem_access && !mem_ready && (m_run < TO);
  endfunction

  // Expected {pc, if_id, id_exe, exe_mem, mem_wb, flush, bubble}.
  function automatic logic [6:0] m_out();
    if (!rst)                     return 7'b11111_00;
    if (m_freeze())               return 7'b00000_00;
    if (br_taken || m_pend)       return 7'b11111_11;
    if (m_hazard())               return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  task automatic mid();
    @(negedge clk);
    chk("outs", 32'({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en,
                     if_id_flush, id_exe_bubble}), 32'(m_out()));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic adv();
    logic [6:0] e;
    bit fz;
    e  = m_out();
    fz = m_freeze();
    @(posedge clk);
    if (!rst) begin
      m_run = 0; m_pend = 0; m_err = 0; m_stall = 0;
    end else begin
      if (!e[6] && m_stall < SMAX) m_stall++;
      if (m_run > 0 && m_run == TO && !mem_ready) m_err = 1;
      m_pend = fz && (m_pend || br_taken);
      m_run  = fz ? m_run + 1 : 0;
    end
    #1;
  endtask

  task automatic clr();
    id_src1 = 0; id_src2 = 0; id_two_src = 0; exe_dest = 0; exe_wb_en = 0;
    exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0; br_taken = 0;
    mem_access = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    mid();
    adv();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [4:0] s1, s2, ed, md;
    logic       two, ewb, emr, mwb, br;
    logic       pc, ifid, bub, fl;
  } vec_t;

  function automatic vec_t mk(int s1, int s2, int two, int ed, int ewb, int emr,
                              int md, int mwb, int br, int pc, int ifid, int bub, int fl);
    vec_t v;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.two = 1'(two); v.ed = 5'(ed);
    v.ewb = 1'(ewb); v.emr = 1'(emr); v.md = 5'(md); v.mwb = 1'(mwb);
    v.br = 1'(br); v.pc = 1'(pc); v.ifid = 1'(ifid); v.bub = 1'(bub); v.fl = 1'(fl);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    clr();
    id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two; exe_dest = v.ed;
    exe_wb_en = v.ewb; exe_mem_r_en = v.emr; mem_dest = v.md; mem_wb_en = v.mwb;
    br_taken = v.br;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(5, 0, 0, 5, 1, 1, 0, 0, 0,  0, 0, 1, 0);
    vecs[1] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0);
    vecs[2] = mk(5, 0, 0, 5, 1, 1, 0, 0, 1,  1, 1, 1, 1);
    vecs[3] = mk(0, 3, 1, 3, 1, 0, 0, 0, 0,  FWD, FWD, 1 - FWD, 0);
    vecs[4] = mk(0, 3, 0, 3, 1, 1, 0, 0, 0,  1, 1, 0, 0);
    vecs[5] = mk(7, 0, 0, 0, 0, 0, 7, 1, 0,  FWD, FWD, 1 - FWD, 0);
    vecs[6] = mk(1, 2, 1, 3, 1, 1, 4, 1, 0,  1, 1, 0, 0);
    vecs[7] = mk(1, 2, 1, 3, 0, 0, 4, 0, 1,  1, 1, 1, 1);
    vecs[8] = mk(7, 0, 0, 0, 0, 0, 7, 0, 0,  1, 1, 0, 0);

    m_run = 0; m_pend = 0; m_err = 0; m_stall = 0;
    clr();
    rst = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i]);
      mid();
      chk($sformatf("v%0d_pc", i), 32'(pc_en), 32'(vecs[i].pc));
      chk($sformatf("v%0d_ifid", i), 32'(if_id_en), 32'(vecs[i].ifid));
      chk($sformatf("v%0d_bub", i), 32'(id_exe_bubble), 32'(vecs[i].bub));
      chk($sformatf("v%0d_fl", i), 32'(if_id_flush), 32'(vecs[i].fl));
      chk($sformatf("v%0d_rest", i), 32'({id_exe_en, exe_mem_en, mem_wb_reg_en}), 32'd7);
      adv();
    end

    // Single load-use cycle leaves exactly one stall counted.
    do_reset();
    apply(vecs[0]);
    mid();
    adv();
    clr();
    mid();
    chk("loaduse_stall", 32'(stall_cnt), 32'd1);
    adv();

    // Three-cycle memory wait then completion.
    do_reset();
    mem_access = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("wait%0d_en", i), 32'({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en}), 32'd0);
      adv();
    end
    mem_ready = 1;
    mid();
    chk("wait_done_en", 32'({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en}), 32'h1f);
    adv();
    clr();
    mid();
    chk("wait_stall", 32'(stall_cnt), 32'd3);
    chk("wait_err", 32'(mem_err), 32'd0);
    adv();

    // Stuck memory: forced release after TO cycles, sticky error, cleared by reset.
    do_reset();
    mem_access = 1;
    for (int i = 0; i < TO; i++) begin
      mid();
      chk($sformatf("to%0d_pc", i), 32'(pc_en), 32'd0);
      adv();
    end
    mid();
    chk("to_release_en", 32'({pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en}), 32'h1f);
    chk("to_err_before", 32'(mem_err), 32'd0);
    adv();
    mid();
    chk("to_err_set", 32'(mem_err), 32'd1);
    adv();
    rst = 1'b0;
    mid();
    chk("to_rst_en", 32'({pc_en, if_id_flush, id_exe_bubble}), 32'h4);
    adv();
    rst = 1'b1;
    clr();
    mid();
    chk("to_err_clr", 32'(mem_err), 32'd0);
    adv();

    // Branch arriving while frozen is acted on once the freeze lifts.
    do_reset();
    mem_access = 1; br_taken = 1;
    mid();
    chk("brf_fl0", 32'({if_id_flush, id_exe_bubble, pc_en}), 32'd0);
    adv();
    br_taken = 0;
    mid();
    chk("brf_fl1", 32'({if_id_flush, id_exe_bubble, pc_en}), 32'd0);
    adv();
    mem_ready = 1;
    mid();
    chk("brf_act", 32'({if_id_flush, id_exe_bubble, pc_en}), 32'h7);
    adv();
    clr();
    mid();
    chk("brf_done", 32'({if_id_flush, id_exe_bubble}), 32'd0);
    adv();

    // Stall counter saturates without wrapping.
    do_reset();
    apply(vecs[0]);
    for (int i = 0; i < SMAX + 5; i++) begin
      mid();
      adv();
    end
    mid();
    chk("stall_sat", 32'(stall_cnt), 32'(SMAX));
    adv();

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 59) != 0);
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_two_src   = 1'($urandom);
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom);
      br_taken     = ($urandom_range(0, 5) == 0);
      mem_access   = ($urandom_range(0, 3) != 0);
      mem_ready    = ($urandom_range(0, 3) == 0);
      mid();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255: the maximum number of consecutive memory-freeze cycles before forced release.
REQ-002 SHALL have parameter STALL_CNT_W, default 16: the width of stall_cnt.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports id_src1 and id_src2, inputs, 5 each: the source register numbers of the instruction in ID.
REQ-006 SHALL have port id_two_src, input, 1: the ID instruction reads id_src2.
REQ-007 SHALL have ports exe_dest (input, 5), exe_wb_en (input, 1) and exe_mem_r_en (input, 1): the ID/EXE register outputs dest, WB_EN and MEM_R_EN.
REQ-008 SHALL have ports mem_dest (input, 5) and mem_wb_en (input, 1): the EXE/MEM register outputs dest and WB_EN.
REQ-009 SHALL have port br_taken, input, 1: a branch in EXE is taken.
REQ-010 SHALL have ports mem_access (input, 1) and mem_ready (input, 1): the MEM stage is reading or writing data memory; data memory is completing the access this cycle.
REQ-011 SHALL have ports pc_en, if_id_en, id_exe_en, exe_mem_en and mem_wb_reg_en, outputs, 1 each: load enables for the PC and the four pipeline registers.
REQ-012 SHALL have ports if_id_flush and id_exe_bubble, outputs, 1 each: clear IF/ID; load a NOP (all control enables 0) into ID/EXE.
REQ-013 SHALL have port mem_err, output, 1: sticky memory-timeout flag.
REQ-014 SHALL have port stall_cnt, output, STALL_CNT_W: saturating count of cycles with pc_en=0.

Function
REQ-015 SHALL drive all enable and flush outputs combinationally from the registered state and the current inputs, with zero-cycle latency.
REQ-016 SHALL define hazard as follows: src matches a dest when the two are equal and nonzero; src2 is considered only when id_two_src=1.
REQ-017 SHALL, with FORWARDING_EN defined, set hazard = exe_mem_r_en AND (id_src1 or id_src2 matches exe_dest).
REQ-018 SHALL, without FORWARDING_EN, set hazard = (exe_wb_en AND src matches exe_dest) OR (mem_wb_en AND src matches mem_dest).
REQ-019 SHALL define freeze = mem_access AND NOT mem_ready AND (wait_cnt != MEM_TIMEOUT).
REQ-020 SHALL, on freeze, drive all five enables to 0 and both flushes to 0; freeze has the highest priority.
REQ-021 SHALL, when not frozen and br_taken=1, drive all enables to 1, if_id_flush=1 and id_exe_bubble=1; branch beats hazard.
REQ-022 SHALL, when not frozen and br_taken=0 and hazard=1, drive pc_en=0, if_id_en=0, id_exe_bubble=1 and every other enable 1.
REQ-023 SHALL otherwise drive all enables to 1 and both flushes to 0.
REQ-024 SHALL use an FSM with states IDLE and WAIT; IDLE->WAIT on an edge where freeze=1; WAIT->WAIT while freeze=1; WAIT->IDLE on an edge where freeze=0.
REQ-025 SHALL use an 8-bit wait_cnt: +1 on each edge with freeze=1, cleared to 0 on each edge with freeze=0; this yields at most MEM_TIMEOUT consecutive frozen cycles.
REQ-026 SHALL set mem_err=1 on an edge where state=WAIT, wait_cnt=MEM_TIMEOUT and mem_ready=0; mem_err holds until reset.
REQ-027 SHALL hold a branch that arrives during freeze (EXE frozen) and act on it in the first unfrozen cycle.
REQ-028 SHALL increment stall_cnt on every edge with pc_en=0, saturating at all ones with no wrap.
REQ-029 SHALL never assert if_id_flush or id_exe_bubble in the same cycle as freeze.

Reset
REQ-030 SHALL, on an edge with rst=0, force state=IDLE, wait_cnt=0, mem_err=0 and stall_cnt=0, including mid-WAIT.
REQ-031 SHALL, while rst=0, drive all enables to 1 and both flushes to 0, so pipeline registers clear under their own reset.

Configuration
REQ-032 SHALL use macro PIPE_HAZARD_FORWARDING_EN: defined selects the REQ-017 hazard (load-use only, forwarding unit present); undefined selects the REQ-018 hazard (stall on any RAW against EXE or MEM); nothing else changes.

Verification
REQ-033 SHALL cover load-use: exe_mem_r_en=1, exe_dest=5, id_src1=5 for 1 cycle -> pc_en=0, if_id_en=0, id_exe_bubble=1 that cycle; stall_cnt=1 after.
REQ-034 SHALL cover register zero: exe_mem_r_en=1, exe_dest=0, id_src1=0 -> no stall; all enables 1.
REQ-035 SHALL cover branch plus hazard: br_taken=1 with a REQ-033 hazard -> if_id_flush=1, id_exe_bubble=1, pc_en=1.
REQ-036 SHALL cover memory wait: mem_access=1, mem_ready=0 for 3 cycles then mem_ready=1 -> all enables 0 for 3 cycles, 1 on the 4th; stall_cnt=3; mem_err=0.
REQ-037 SHALL cover timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> 4 frozen cycles, enables 1 on the 5th cycle, mem_err=1 after that edge; rst=0 clears it.
REQ-038 SHALL cover the macro: exe_wb_en=1, exe_dest=3, id_src2=3, id_two_src=1, exe_mem_r_en=0 -> stall without the macro; no stall with it.
